aes256_key_scheduler: RTL and testbench
=======================================

# aes256_key_scheduler

Controller and round-key store for AES-256 encryption. It accepts a 256-bit cipher key over a valid/ready handshake and sequences a one-round-key-per-cycle expansion step. It writes all 15 round keys (rk0..rk14) into an internal register file and serves them to the cipher round engine through a registered random-access read port, with a status flag that marks the key set as complete.

## Interface
- NR, 14: number of rounds; the store holds NR+1 = 15 round keys.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- key_valid  in  1  new cipher key presented
- key_in  in  256  cipher key; bits [255:224] are word w0
- key_ready  out  1  scheduler can accept a key this cycle
- rk_idx  in  4  round-key index requested by the round engine
- rk_out  out  128  round key rk[rk_idx], registered; bits [127:96] are the lowest-numbered word
- keys_valid  out  1  all 15 round keys for the current key are stored
- busy  out  1  expansion in progress

## Operation
- States are IDLE, EXPAND and DONE.
- IDLE:
  - key_ready = 1.
  - On key_valid && key_ready, write rk[0] = key_in[255:128] and rk[1] = key_in[127:0], load widx = 8, and go to EXPAND.
- EXPAND:
  - key_ready = 0 and busy = 1.
  - Each cycle, the step sub-module computes words widx..widx+3 from rk[r-2] and rk[r-1], where r = widx/4. The result is written to rk[r].
  - widx increments by 4 each cycle.
  - The cycle that writes rk[14] (widx = 56) transitions to DONE.
- DONE:
  - keys_valid = 1 and key_ready = 1.
  - Accepting a new key behaves as in IDLE. keys_valid deasserts on the next cycle and the old key set is overwritten.
- Word rule for i in 8..59:
  - w[i] = w[i-8] ^ t.
  - If i%8 == 0: t = SubWord(RotWord(w[i-1])) ^ {Rcon[i/8], 24'h0}.
  - If i%8 == 4: t = SubWord(w[i-1]).
  - Otherwise: t = w[i-1].
  - Rcon[1..7] = 01, 02, 04, 08, 10, 20, 40.
- Words within one step chain combinationally (w[i+1] uses the new w[i]).
- Read port:
  - rk_out <= rk[rk_idx] every cycle, regardless of state.
  - rk_idx of 15 returns 128'h0.
  - Reads during EXPAND return whatever is currently stored. Consumers must gate on keys_valid.
- key_valid with key_ready = 0 is ignored. The source must hold the key until the handshake completes.
- Reset values:
  - state = IDLE, widx = 0, all rk[] = 0, rk_out = 0.
  - keys_valid = 0, busy = 0, key_ready = 0 in the reset cycle and 1 afterwards.
- Reset asserted mid-EXPAND aborts the expansion and clears the store. No partial key set is ever flagged valid.

## Timing
- Key handshake in cycle T: rk0/rk1 are readable via rk_out from T+2 (address at T+1, data at T+2).
- rk[k] for k = 2..14 is written at the end of cycle T+k-1.
- keys_valid and key_ready are high from cycle T+14. busy is high for cycles T+1..T+13, i.e. 13 cycles.
- Read latency is 1 cycle, fixed.
- Back-to-back keys: the earliest next handshake is at T+14, so throughput is one key per 14 cycles.
- A read of rk[k] in the same cycle it is written returns the old value. There is no bypass.

## Structure
- aes_pkg holds:
  - parameters NK = 8 and NR = 14
  - typedefs word_t (32 bit), round_key_t (128 bit) and cipher_key_t (256 bit)
  - the Rcon table as a constant function or array
  - the state enum
- Sub-module aes256_key_step (combinational):
  - Inputs: widx, rk_prev2, rk_prev1. Output: round_key_t.
  - Internally four word stages, using four instances of the team's existing sbox for SubWord.
- The top module holds the FSM, widx, the 15-entry register file and the read register.

## Test plan
- FIPS-197 key 000102..1f:
  - rk0 = 00010203_04050607_08090a0b_0c0d0e0f and rk1 = 10111213_14151617_18191a1b_1c1d1e1f.
  - rk2 = a573c29f_a176c498_a97fce93_a572c09c.
  - rk14 = 24fc79cc_bf0979e9_371ac23c_6d68de36.
  - keys_valid rises exactly 14 cycles after the handshake.
- Key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4:
  - rk2 = 9ba35411_8e6925af_a51a8b5f_2067fcde.
  - rk14 = fe4890d1_e6188d0b_046df344_706c631e.
- key_valid held high during EXPAND with a different key: it is ignored, and the key set matches the first key.
- New key accepted in DONE: keys_valid falls on the next cycle. The new set is valid after 14 cycles, and the old rk14 is replaced.
- Reset asserted at the 6th EXPAND cycle:
  - keys_valid = 0, busy = 0, and reads of rk[0..14] return 0.
  - A subsequent key expands correctly.
- Sweep rk_idx 0..15 in DONE: data appears one cycle later, and index 15 returns 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types, sizes and round-constant lookup for the AES-256 key schedule.
package aes_pkg;

    localparam int NK = 8;
    localparam int NR = 14;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] round_key_t;
    typedef logic [255:0] cipher_key_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } state_e;

    // Rcon indexed by word index: Rcon[widx/8]; only indices 1..7 occur in AES-256.
    function automatic logic [7:0] rcon(input logic [5:0] widx);
        logic [5:0] r;
        r = widx >> 3;
        case (r)
            6'd1:    rcon = 8'h01;
            6'd2:    rcon = 8'h02;
            6'd3:    rcon = 8'h04;
            6'd4:    rcon = 8'h08;
            6'd5:    rcon = 8'h10;
            6'd6:    rcon = 8'h20;
            6'd7:    rcon = 8'h40;
            default: rcon = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes256_key_step.sv
// One AES-256 expansion step: produces words widx..widx+3 (one round key) from the two previous round keys.
module aes256_key_step
    import aes_pkg::*;
(
    input  logic [5:0] widx_i,
    input  round_key_t rk_prev2_i,
    input  word_t      rk_prev1_w3_i,
    output round_key_t rk_o
);

    word_t      sub_w;
    word_t      t0;
    word_t      w0;
    word_t      w1;
    word_t      w2;
    word_t      w3;
    logic [7:0] rc;

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .in_i  (rk_prev1_w3_i[b*8 +: 8]),
            .out_o (sub_w[b*8 +: 8])
        );
    end

    // SubWord(RotWord(x)) equals RotWord(SubWord(x)), so one SubWord serves both cases.
    always_comb begin
        rc = rcon(widx_i);
        if (widx_i[2]) begin
            t0 = sub_w;
        end else begin
            t0 = {sub_w[23:0], sub_w[31:24]} ^ {rc, 24'h0};
        end
        w0   = rk_prev2_i[127:96] ^ t0;
        w1   = rk_prev2_i[95:64]  ^ w0;
        w2   = rk_prev2_i[63:32]  ^ w1;
        w3   = rk_prev2_i[31:0]   ^ w2;
        rk_o = {w0, w1, w2, w3};
    end

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box, combinational byte lookup.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX[{in_i, 3'b000} +: 8];

endmodule

// File: rtl/aes256_key_scheduler.sv
// AES-256 key scheduler: accepts a cipher key, expands one round key per cycle into
// a 15-entry store, and serves round keys through a registered read port.
module aes256_key_scheduler
    import aes_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           key_valid,
    input  logic [255:0]   key_in,
    output logic           key_ready,
    input  logic [3:0]     rk_idx,
    output logic [127:0]   rk_out,
    output logic           keys_valid,
    output logic           busy
);

    state_e     state_q;
    state_e     state_d;
    logic [5:0] widx_q;
    logic [5:0] widx_d;
    round_key_t rk_q [NR+1];
    round_key_t rk_out_q;
    round_key_t step_rk;
    round_key_t prev2_rk;
    word_t      prev1_w3;
    logic [3:0] r_idx;
    logic [3:0] p1_idx;
    logic [3:0] p2_idx;
    logic       load_key;
    logic       step_we;

    assign r_idx  = widx_q[5:2];
    assign p1_idx = r_idx - 4'd1;
    assign p2_idx = r_idx - 4'd2;

    // Outside EXPAND the step inputs are don't-care; clamp so no read falls off the store.
    always_comb begin
        prev2_rk = (p2_idx < 4'd15) ? rk_q[p2_idx] : '0;
        prev1_w3 = (p1_idx < 4'd15) ? rk_q[p1_idx][31:0] : '0;
    end

    aes256_key_step u_step (
        .widx_i        (widx_q),
        .rk_prev2_i    (prev2_rk),
        .rk_prev1_w3_i (prev1_w3),
        .rk_o          (step_rk)
    );

    always_comb begin
        state_d    = state_q;
        widx_d     = widx_q;
        load_key   = 1'b0;
        step_we    = 1'b0;
        key_ready  = 1'b0;
        keys_valid = 1'b0;
        busy       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                key_ready = !reset;
                if (key_valid && key_ready) begin
                    load_key = 1'b1;
                    widx_d   = 6'd8;
                    state_d  = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                busy    = !reset;
                step_we = 1'b1;
                widx_d  = widx_q + 6'd4;
                if (widx_q == 6'd56) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                key_ready  = !reset;
                keys_valid = !reset;
                if (key_valid && key_ready) begin
                    load_key = 1'b1;
                    widx_d   = 6'd8;
                    state_d  = ST_EXPAND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            widx_q   <= '0;
            rk_out_q <= '0;
            for (int k = 0; k < NR + 1; k++) begin
                rk_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            if (load_key) begin
                rk_q[0] <= key_in[255:128];
                rk_q[1] <= key_in[127:0];
            end
            if (step_we && (r_idx < 4'd15)) begin
                rk_q[r_idx] <= step_rk;
            end
            rk_out_q <= (rk_idx == 4'd15) ? '0 : rk_q[rk_idx];
        end
    end

    assign rk_out = rk_out_q;

endmodule

// File: tb/tb_aes256_key_scheduler.sv
// Self-checking bench for aes256_key_scheduler against a GF(2^8)-arithmetic key-expansion model.
module tb_aes256_key_scheduler;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         key_valid = 1'b0;
    logic [255:0] key_in = '0;
    logic         key_ready;
    logic [3:0]   rk_idx = '0;
    logic [127:0] rk_out;
    logic         keys_valid;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_rk [16];

    typedef struct {
        logic [255:0] key;
        logic [127:0] rk2;
        logic [127:0] rk14;
    } vec_t;

    vec_t vecs [2];

    always #5 clk = ~clk;

    aes256_key_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out),
        .keys_valid (keys_valid),
        .busy       (busy)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] s;
        inv = 8'h00;
        if (x != 8'h00) begin
            for (int c = 1; c < 256; c++) begin
                if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
            end
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] subword_ref(input logic [31:0] w);
        return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
    endfunction

    task automatic build_model(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subword_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subword_ref(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int k = 0; k < 15; k++) exp_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        exp_rk[15] = '0;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] val);
        rk_idx = idx;
        tick();
        val = rk_out;
    endtask

    task automatic sweep(input string tag);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) begin
            read_rk(4'(i), v);
            check($sformatf("%s rk[%0d]", tag, i), v, exp_rk[i]);
        end
    endtask

    task automatic random_key(output logic [255:0] k);
        for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom();
    endtask

    // Handshake in cycle T, then track status T+1..T+14; optionally keep offering another key.
    task automatic load_key(input logic [255:0] key, input bit hold, input logic [255:0] other);
        int waited;
        waited = 0;
        while (!key_ready && waited < 40) begin
            tick();
            waited++;
        end
        check("key_ready_before_load", {127'h0, key_ready}, 128'h1);
        key_in    = key;
        key_valid = 1'b1;
        tick();
        rk_idx = 4'd0;
        for (int k = 1; k <= 14; k++) begin
            check($sformatf("status T+%0d {busy,keys_valid,key_ready}", k),
                  {125'h0, busy, keys_valid, key_ready},
                  {125'h0, (k <= 13), (k == 14), (k == 14)});
            if (k == 2) check("rk0 readable at T+2", rk_out, key[255:128]);
            if (hold && k <= 12) begin
                key_valid = 1'b1;
                key_in    = other;
            end else begin
                key_valid = 1'b0;
            end
            if (k < 14) tick();
        end
    endtask

    initial begin
        logic [255:0] ka;
        logic [255:0] kb;
        logic [127:0] v;

        vecs[0].key  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        vecs[0].rk2  = 128'ha573c29fa176c498a97fce93a572c09c;
        vecs[0].rk14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
        vecs[1].key  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        vecs[1].rk2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
        vecs[1].rk14 = 128'hfe4890d1e6188d0b046df344706c631e;

        tick();
        tick();
        check("reset key_ready", {127'h0, key_ready}, 128'h0);
        check("reset {busy,keys_valid}", {126'h0, busy, keys_valid}, 128'h0);
        check("reset rk_out", rk_out, 128'h0);
        reset = 1'b0;
        #1;
        check("key_ready after reset", {127'h0, key_ready}, 128'h1);

        for (int i = 0; i < 2; i++) begin
            build_model(vecs[i].key);
            load_key(vecs[i].key, 1'b0, '0);
            read_rk(4'd2, v);
            check($sformatf("vec%0d rk2", i), v, vecs[i].rk2);
            read_rk(4'd14, v);
            check($sformatf("vec%0d rk14", i), v, vecs[i].rk14);
            sweep($sformatf("vec%0d", i));
        end

        random_key(ka);
        random_key(kb);
        build_model(ka);
        load_key(ka, 1'b1, kb);
        sweep("hold_ignored");

        random_key(ka);
        key_in    = ka;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (5) tick();
        check("busy at 6th expand cycle", {127'h0, busy}, 128'h1);
        reset = 1'b1;
        #1;
        check("abort reset cycle {busy,keys_valid,key_ready}",
              {125'h0, busy, keys_valid, key_ready}, 128'h0);
        tick();
        reset = 1'b0;
        #1;
        check("after abort {busy,keys_valid,key_ready}",
              {125'h0, busy, keys_valid, key_ready}, 128'h1);
        for (int k = 0; k < 16; k++) exp_rk[k] = '0;
        sweep("after_abort");

        for (int n = 0; n < 3; n++) begin
            random_key(ka);
            build_model(ka);
            load_key(ka, 1'b0, '0);
            sweep($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
